// File: rtl/uart_tx_pkg.sv
// uart_tx_periph shared definitions: register map, STATUS bits, FSM states.
package uart_tx_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVR   = 3;
  localparam int ST_IEN   = 7;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uart_tx_periph_byte_fifo.sv
// Byte FIFO for the UART transmitter; full/empty are registered flags.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr_nx;
  logic [AW-1:0] rptr_nx;
  logic          do_push;
  logic          do_pop;

  // Push is gated by the registered full flag, so a
  // same-cycle pop never makes room for it.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign wptr_nx = wptr + AW'(1);
  assign rptr_nx = rptr + AW'(1);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr_nx;
      if (do_pop)  rptr <= rptr_nx;
      if (do_push && !do_pop) begin
        empty <= 1'b0;
        full  <= (wptr_nx == rptr);
      end else if (do_pop && !do_push) begin
        full  <= 1'b0;
        empty <= (rptr_nx == wptr);
      end
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with byte FIFO.
// Optional interrupt enable/irq built when UART_TX_IRQ_EN is defined.
module uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter int DIV_DEFAULT = 234,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       tx,
  output logic       irq
);

  logic       wr;
  logic       rd;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  tx_state_e  state;
  logic [15:0] div;
  logic [15:0] div_act;
  logic [15:0] cnt;
  logic        cnt_end;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        overrun;
  logic        ien;
  logic [7:0]  status;
  logic [7:0]  rsel;

  assign wr        = cs & we;
  assign rd        = cs & ~we;
  assign fifo_push = wr && (addr == REG_DATA);
  assign cnt_end   = (cnt == div_act - 16'd1);
  assign fifo_pop  = !fifo_empty &&
                     (state == S_IDLE ||
                      (state == S_STOP && cnt_end));

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (wdata),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef UART_TX_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ien   <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr && addr == REG_STATUS) ien <= wdata[ST_IEN];
      irq_q <= ien & fifo_empty & (state == S_IDLE);
    end
  end

  assign irq = irq_q;
`else
  assign ien = 1'b0;
  assign irq = 1'b0;
`endif

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = (state != S_IDLE) | ~fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_OVR]   = overrun;
    status[ST_IEN]   = ien;
  end

  always_comb begin
    rsel = '0;
    unique case (1'b1)
      addr == REG_STATUS: rsel = status;
      addr == REG_DIV_LO: rsel = div[7:0];
      addr == REG_DIV_HI: rsel = div[15:8];
      default:            rsel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= 16'(DIV_DEFAULT);
      overrun <= 1'b0;
      rdata   <= '0;
    end else begin
      if (rd) rdata <= rsel;
      if (wr && addr == REG_DIV_LO) div[7:0]  <= wdata;
      if (wr && addr == REG_DIV_HI) div[15:8] <= wdata;
      // Reader sees overrun=1 on the clearing read.
      if (fifo_push && fifo_full)
        overrun <= 1'b1;
      else if (rd && addr == REG_STATUS)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      shreg   <= '0;
      div_act <= DIV_MIN;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            state   <= S_START;
            tx      <= 1'b0;
            shreg   <= fifo_dout;
            div_act <= eff_div(div);
            cnt     <= '0;
          end
        end
        S_START: begin
          if (cnt_end) begin
            state   <= S_DATA;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (cnt_end) begin
            cnt <= '0;
            if (fifo_pop) begin
              state   <= S_START;
              tx      <= 1'b0;
              shreg   <= fifo_dout;
              div_act <= eff_div(div);
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with a serial-line scoreboard.
module tb_uart_tx_periph;
  import uart_tx_pkg::*;

  logic       clk;
  logic       reset;
  logic       cs;
  logic [1:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       tx;
  logic       irq;

  typedef struct {
    logic [7:0] data;
    int         dv;
  } sb_t;

  sb_t sb[$];
  int  starts[$];
  int  n_assert = 0;
  int  n_fail = 0;
  int  frames_done = 0;
  int  cyc = 0;
  bit  mon_kill = 0;

  uart_tx_periph dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    cs = 1'b1; we = 1'b0; addr = a;
    tick();
    cs = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int dv);
    sb.push_back('{d, dv});
    bus_wr(REG_DATA, d);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_done < n && k < budget) begin
      tick();
      k++;
    end
    chk("frame_timeout", 32'(frames_done), 32'(n));
  endtask

  // Line monitor: every frame must match the oldest queued byte,
  // with every bit held for exactly that frame's divisor.
  initial begin : monitor
    int         m_i;
    int         m_div;
    bit         m_act;
    bit         m_bad;
    logic [9:0] m_bits;
    sb_t        m_exp;
    m_act = 0;
    m_i = 0;
    m_div = 1;
    m_bad = 0;
    m_bits = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mon_kill) begin
        m_act = 0;
      end else begin
        if (!m_act && tx === 1'b0) begin
          chk("unexpected_frame", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            m_exp = sb.pop_front();
            m_div = m_exp.dv;
            m_i = 0;
            m_bad = 0;
            m_bits = '0;
            m_act = 1;
            starts.push_back(cyc);
          end
        end
        if (m_act) begin
          if (m_i % m_div == 0)
            m_bits[m_i / m_div] = tx;
          else if (tx !== m_bits[m_i / m_div])
            m_bad = 1;
          m_i++;
          if (m_i == 10 * m_div) begin
            m_act = 0;
            chk("frame_bits", 32'(m_bits),
                32'({1'b1, m_exp.data, 1'b0}));
            chk("bit_width", 32'(m_bad), 32'd0);
            frames_done++;
          end
        end
      end
    end
  end

  initial begin : stim
    int fd;
    reset = 1'b1; cs = 1'b0; we = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    bus_rd(REG_STATUS);
    chk("rst_status", 32'(rdata), 32'h04);
    bus_rd(REG_DIV_LO);
    chk("rst_div_lo", 32'(rdata), 32'd234);

    // single frame, div = 4
    bus_wr(REG_DIV_LO, 8'd4);
    bus_rd(REG_DIV_LO);
    chk("div_lo_rd", 32'(rdata), 32'd4);
    send(8'h55, 4);
    chk("tx_n1", 32'(tx), 32'd1);
    tick();
    chk("tx_fall_n2", 32'(tx), 32'd0);
    wait_frames(1, 100);
    bus_rd(REG_STATUS);
    chk("status_idle", 32'(rdata), 32'h04);
    repeat (3) tick();
    chk("rdata_hold", 32'(rdata), 32'h04);

    // fill FIFO, overrun, divisor change for later frames
    bus_wr(REG_DIV_LO, 8'd100);
    for (int i = 0; i < 17; i++)
      send(8'(8'h30 + i), (i == 0) ? 100 : 4);
    bus_rd(REG_STATUS);
    chk("status_full", 32'(rdata), 32'h03);
    bus_wr(REG_DATA, 8'hEE);
    bus_rd(REG_STATUS);
    chk("status_ovr", 32'(rdata), 32'h0B);
    bus_rd(REG_STATUS);
    chk("status_ovr_clr", 32'(rdata), 32'h03);
    bus_wr(REG_DIV_LO, 8'd4);
    wait_frames(18, 3000);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    bus_rd(REG_STATUS);
    chk("status_after_fill", 32'(rdata), 32'h04);

    // divisor written mid-frame
    starts.delete();
    send(8'hA3, 4);
    send(8'h3C, 8);
    bus_wr(REG_DIV_LO, 8'd8);
    wait_frames(20, 400);
    chk("starts_cnt", 32'(starts.size()), 32'd2);
    chk("b2b_gap",
        (starts.size() == 2) ? 32'(starts[1] - starts[0]) : 32'hFFFF,
        32'd40);

    // reset in the middle of a data bit
    send(8'h11, 8);
    send(8'h22, 8);
    send(8'h33, 8);
    repeat (20) tick();
    mon_kill = 1;
    reset = 1'b1;
    tick();
    chk("tx_rst", 32'(tx), 32'd1);
    chk("rdata_rst", 32'(rdata), 32'h00);
    reset = 1'b0;
    sb.delete();
    tick();
    mon_kill = 0;
    fd = frames_done;
    bus_rd(REG_STATUS);
    chk("status_post_rst", 32'(rdata), 32'h04);
    repeat (300) tick();
    chk("no_frames_post_rst", 32'(frames_done), 32'(fd));
    chk("tx_idle_post_rst", 32'(tx), 32'd1);

    // interrupt
    bus_wr(REG_DIV_LO, 8'd4);
`ifdef UART_TX_IRQ_EN
    bus_wr(REG_STATUS, 8'h80);
    tick();
    chk("irq_en", 32'(irq), 32'd1);
    send(8'h5A, 4);
    tick();
    chk("irq_busy", 32'(irq), 32'd0);
    wait_frames(fd + 1, 100);
    chk("irq_pre", 32'(irq), 32'd0);
    tick();
    chk("irq_rise", 32'(irq), 32'd1);
    bus_rd(REG_STATUS);
    chk("status_ien", 32'(rdata), 32'h84);
    bus_wr(REG_STATUS, 8'h00);
    tick();
    chk("irq_drop", 32'(irq), 32'd0);
`else
    bus_wr(REG_STATUS, 8'h80);
    bus_rd(REG_STATUS);
    chk("status_no_ien", 32'(rdata), 32'h04);
    send(8'h5A, 4);
    wait_frames(fd + 1, 100);
    repeat (2) tick();
    chk("irq_tied", 32'(irq), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter for the 6502 FPGA system, sitting on the CPU bus next to the LED/button port at $6000/$6001. The top level decodes $6010–$6013 into `cs`. CPU writes to the DATA register are queued in a byte FIFO and serialised 8N1 on `tx`. Read data is registered, so it lines up with the top level's registered DI mux: it is valid on the cycle after the access.

## Interface
- `DIV_DEFAULT`, 234: reset value of the bit-period divisor, in clocks (27 MHz / 115200).
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `clk`  in  1  system clock, the same clock as the CPU.
- `reset`  in  1  synchronous, active-high reset.
- `cs`  in  1  register select; the top level asserts it for AB[15:2] == $6010>>2.
- `addr`  in  2  register offset, AB[1:0].
- `we`  in  1  CPU write enable.
- `wdata`  in  8  CPU data out (DO).
- `rdata`  out  8  registered read data.
- `tx`  out  1  serial line; idles high.
- `irq`  out  1  interrupt request, active-high, level.

## Operation
- Register map:
  - **0 DATA**
    - Write pushes `wdata` if the FIFO is not full.
    - Write while full drops the byte and sets `overrun`.
    - Read returns $00.
  - **1 STATUS**
    - Read: bit0 `busy` (FSM not IDLE or FIFO non-empty), bit1 `full`, bit2 `empty`, bit3 `overrun`, bit7 `ien`, bits 6:4 = 0.
    - A read clears `overrun` on the same edge; the returned value still shows it set.
    - Write: bit7 → `ien`; other bits ignored.
  - **2 DIV_LO**, **3 DIV_HI**
    - Read/write the 16-bit divisor `div`.
    - Values below 2 are treated as 2.
- A register access is a cycle with `cs` = 1. A write is an access with `we` = 1. An access with `cs` = 0 has no effect.
- The FIFO uses a full flag that is registered, not a count compare. A push at full is rejected even if a pop happens in the same cycle.
- Transmit FSM: IDLE → START → DATA → STOP.
  - **IDLE**: if FIFO non-empty, pop into the 8-bit shift register, latch `div` into `div_act`, go to START.
  - **START**: `tx` = 0 for `div_act` clocks.
  - **DATA**: 8 bits, LSB first, `div_act` clocks each. A 3-bit index counts them.
  - **STOP**: `tx` = 1 for `div_act` clocks.
  - At the end of STOP: if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- A divisor write takes effect at the next frame start. A frame in progress keeps `div_act`.
- `tx` is driven from a flop, so there is no combinational path from the FSM.

## Timing
- Reset values:
  - `rdata` = $00, `tx` = 1, `irq` = 0.
  - FIFO empty, `overrun` = 0, `ien` = 0, `div` = `DIV_DEFAULT`, FSM in IDLE.
- Reset asserted mid-frame: `tx` = 1 on the next edge and the frame is aborted. The FIFO contents are discarded.
- Read latency: `rdata` is valid 1 cycle after the access cycle. `rdata` holds its value while `cs` = 0.
- Write latency:
  - A DATA write in cycle N, with the FIFO empty and the FSM idle, gives FIFO non-empty at N+1.
  - The pop happens at N+1.
  - `tx` falls at N+2.
- A frame lasts exactly 10 × `div_act` clocks. Back-to-back frames have no gap.
- The FIFO pointers wrap modulo `FIFO_DEPTH`. `empty` and `full` are never both 1.
- `irq` is registered: `irq` = `ien` & `empty` & (FSM == IDLE), one cycle after the condition becomes true.

## Configuration
- `UART_TX_IRQ_EN` defined: `ien` bit and `irq` behave as above.
- `UART_TX_IRQ_EN` undefined:
  - `irq` is tied to 0.
  - STATUS bit7 reads 0.
  - Writes to bit7 are ignored.
  - No `ien` flop is built.

## Structure
- Package `uart_tx_pkg`:
  - register offsets (`REG_DATA`, `REG_STATUS`, `REG_DIV_LO`, `REG_DIV_HI`);
  - STATUS bit positions;
  - FSM state encoding;
  - minimum divisor (2).
- Sub-module `byte_fifo`:
  - synchronous FIFO with parameter `DEPTH`;
  - ports `push`/`din`/`pop`/`dout`/`full`/`empty`;
  - registered full/empty flags.
- The top half of the block holds the register file, the bit timer, and the FSM.

## Test plan
- Reset, then read STATUS → `rdata` = $04 one cycle later; `tx` = 1; `irq` = 0.
- Write $55 to DATA with `div` = 4 → `tx` falls 2 cycles after the write. Line sequence is 0,1,0,1,0,1,0,1,0,1, each 4 clocks. Frame is 40 clocks. STATUS then reads $04.
- Write 17 bytes back-to-back with `div` = 100, `FIFO_DEPTH` = 16, and the first byte popped → no byte dropped. An 18th write while STATUS shows `full` sets `overrun`. STATUS reads $0B; the next STATUS read shows bit3 = 0.
- Write DIV = 8 in the middle of a `div` = 4 frame → the current frame stays 40 clocks; the next queued frame is 80 clocks.
- Assert `reset` in the middle of a DATA bit with 3 bytes queued → `tx` = 1 next cycle; STATUS reads $04; no further frames are sent.
- With `UART_TX_IRQ_EN`: write STATUS = $80, send one byte → `irq` rises 1 cycle after STOP ends. Writing STATUS = $00 drops `irq` on the next cycle.
